// File: rtl/btn_press_driver_if.sv
// Host command handshake plus the synthesized button line and status pulses.
// Commands transfer on cmd_valid & cmd_ready; no backpressure on the status outputs.
interface btn_press_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_color;
    logic       cmd_ready;
    logic       btn;
    logic [1:0] cur_color;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_color,
        input  cmd_ready, btn, cur_color, done, err
    );

    modport slave (
        input  cmd_valid, cmd_color,
        output cmd_ready, btn, cur_color, done, err
    );
endinterface

// File: rtl/btn_press_driver.sv
// Steps an R->G->B colour cycler to a target colour with the fewest debounced presses.
// n presses take n*(HOLD+GAP) cycles before done; cmd_ready is high only while idle.
module btn_press_driver #(
    parameter int HOLD_TICKS = 1000,
    parameter int GAP_TICKS  = 1000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    btn_press_driver_if.slave  bus
);
    localparam int MAX_TICKS = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    rem_q, rem_d;
    logic [1:0]    color_q, color_d;
    logic          btn_q, btn_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [2:0]    diff;
    logic [1:0]    n_presses;
    logic [1:0]    color_next;
    logic          hold_last;
    logic          gap_last;

    // Forward distance around the three-colour ring, always 0..2.
    always_comb begin
        diff      = {1'b0, bus.cmd_color} + 3'd3 - {1'b0, color_q};
        n_presses = (diff >= 3'd3) ? 2'(diff - 3'd3) : diff[1:0];
    end

    assign color_next = (color_q == 2'd2) ? 2'd0 : color_q + 2'd1;
    assign hold_last  = (tick_q == TW'(HOLD_TICKS - 1));
    assign gap_last   = (tick_q == TW'(GAP_TICKS - 1));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        rem_d   = rem_q;
        color_d = color_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (bus.cmd_valid) begin
                    if (bus.cmd_color == 2'd3) begin
                        err_d = 1'b1;
                    end else if (n_presses == 2'd0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = n_presses;
                        state_d = PRESS;
                    end
                end
            end
            PRESS: begin
                if (hold_last) begin
                    tick_d  = '0;
                    color_d = color_next;
                    rem_d   = rem_q - 2'd1;
                    state_d = GAP;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            GAP: begin
                if (gap_last) begin
                    tick_d = '0;
                    if (rem_q != 2'd0) begin
                        state_d = PRESS;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase
        btn_d = (state_d == PRESS);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tick_q  <= '0;
            rem_q   <= '0;
            color_q <= '0;
            btn_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
            color_q <= color_d;
            btn_q   <= btn_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.btn       = btn_q;
    assign bus.cur_color = color_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_btn_press_driver.sv
// Scenario bench for btn_press_driver with HOLD=4, GAP=3; completions are scoreboarded.
module tb_btn_press_driver;
    localparam int H = 4;
    localparam int G = 3;
    localparam int P = H + G;

    typedef struct packed {
        logic       is_err;
        logic [1:0] color;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    btn_press_driver_if bus();

    btn_press_driver #(.HOLD_TICKS(H), .GAP_TICKS(G)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Completion monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (bus.done === 1'b1 || bus.err === 1'b1) begin
            checks++;
            if (bus.done === 1'b1 && bus.err === 1'b1) begin
                errors++;
                $display("FAIL sb_both: done=%b err=%b, must not be high together", bus.done, bus.err);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: done=%b err=%b with no command outstanding", bus.done, bus.err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.err, bus.cur_color} !== {e.is_err, e.color}) begin
                    errors++;
                    $display("FAIL sb_result: got err=%b cur=%0d, want err=%b cur=%0d",
                             bus.err, bus.cur_color, e.is_err, e.color);
                end
            end
        end
    end

    // Presents one command for the accept cycle; returns just after the accept edge (cycle 1).
    task automatic issue(input logic [1:0] c, input logic exp_err, input logic [1:0] exp_col);
        exp_t e;
        e.is_err = exp_err;
        e.color  = exp_col;
        sb.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_color = c;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_color = 2'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_color = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.btn, bus.cur_color, bus.cmd_ready, bus.done, bus.err} !== 6'b0_00_1_0_0) begin
                errors++;
                $display("FAIL reset_state c%0d: btn=%b cur=%0d rdy=%b done=%b err=%b, want 0 0 1 0 0",
                         c, bus.btn, bus.cur_color, bus.cmd_ready, bus.done, bus.err);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r_to_b();
        issue(2'd2, 1'b0, 2'd2);
        for (int c = 1; c <= 16; c++) begin
            logic       eb, er, ed;
            logic [1:0] ec;
            @(negedge clk);
            eb = (c >= 1 && c <= 4) || (c >= 8 && c <= 11);
            ec = (c < 5) ? 2'd0 : (c < 12) ? 2'd1 : 2'd2;
            er = (c >= 15);
            ed = (c == 15);
            checks++;
            if ({bus.btn, bus.cur_color, bus.cmd_ready, bus.done} !== {eb, ec, er, ed}) begin
                errors++;
                $display("FAIL r_to_b c%0d: btn=%b cur=%0d rdy=%b done=%b, want %b %0d %b %b",
                         c, bus.btn, bus.cur_color, bus.cmd_ready, bus.done, eb, ec, er, ed);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        issue(2'd0, 1'b0, 2'd0);
        for (int c = 1; c <= 9; c++) begin
            logic       eb, ed;
            logic [1:0] ec;
            @(negedge clk);
            eb = (c >= 1 && c <= H);
            ec = (c <= H) ? 2'd2 : 2'd0;
            ed = (c == P + 1);
            checks++;
            if ({bus.btn, bus.cur_color, bus.done} !== {eb, ec, ed}) begin
                errors++;
                $display("FAIL wrap c%0d: btn=%b cur=%0d done=%b, want %b %0d %b",
                         c, bus.btn, bus.cur_color, bus.done, eb, ec, ed);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_noop();
        issue(2'd0, 1'b0, 2'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.btn, bus.cur_color, bus.cmd_ready, bus.done, bus.err} !== {1'b0, 2'd0, 1'b1, (c == 1), 1'b0}) begin
                errors++;
                $display("FAIL noop c%0d: btn=%b cur=%0d rdy=%b done=%b err=%b, want 0 0 1 %b 0",
                         c, bus.btn, bus.cur_color, bus.cmd_ready, bus.done, bus.err, (c == 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        issue(2'd3, 1'b1, 2'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.btn, bus.cur_color, bus.cmd_ready, bus.done, bus.err} !== {1'b0, 2'd0, 1'b1, 1'b0, (c == 1)}) begin
                errors++;
                $display("FAIL illegal c%0d: btn=%b cur=%0d rdy=%b done=%b err=%b, want 0 0 1 0 %b",
                         c, bus.btn, bus.cur_color, bus.cmd_ready, bus.done, bus.err, (c == 1));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy();
        issue(2'd1, 1'b0, 2'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_color = 2'd2;
        for (int c = 1; c <= 10; c++) begin
            logic       eb, ed;
            logic [1:0] ec;
            @(negedge clk);
            eb = (c >= 1 && c <= H);
            ec = (c <= H) ? 2'd0 : 2'd1;
            ed = (c == P + 1);
            checks++;
            if ({bus.btn, bus.cur_color, bus.done} !== {eb, ec, ed}) begin
                errors++;
                $display("FAIL busy c%0d: btn=%b cur=%0d done=%b, want %b %0d %b",
                         c, bus.btn, bus.cur_color, bus.done, eb, ec, ed);
            end
            @(posedge clk); #1;
            if (c == H) bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midpress();
        issue(2'd2, 1'b0, 2'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.btn !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pressing: btn=%b, want 1", bus.btn);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.btn, bus.cur_color, bus.cmd_ready, bus.done} !== 5'b0_00_1_0) begin
                errors++;
                $display("FAIL rst_mid c%0d: btn=%b cur=%0d rdy=%b done=%b, want 0 0 1 0",
                         c, bus.btn, bus.cur_color, bus.cmd_ready, bus.done);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        issue(2'd1, 1'b0, 2'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_color = 2'd2;
        for (int c = 1; c <= 18; c++) begin
            logic       eb, ed, er;
            logic [1:0] ec;
            @(negedge clk);
            eb = (c >= 1 && c <= 4) || (c >= 9 && c <= 12);
            ec = (c < 5) ? 2'd0 : (c < 13) ? 2'd1 : 2'd2;
            ed = (c == 8) || (c == 16);
            er = (c == 8) || (c >= 16);
            checks++;
            if ({bus.btn, bus.cur_color, bus.cmd_ready, bus.done} !== {eb, ec, er, ed}) begin
                errors++;
                $display("FAIL b2b c%0d: btn=%b cur=%0d rdy=%b done=%b, want %b %0d %b %b",
                         c, bus.btn, bus.cur_color, bus.cmd_ready, bus.done, eb, ec, er, ed);
            end
            if (c == 8) begin
                exp_t e;
                e.is_err = 1'b0;
                e.color  = 2'd2;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            if (c == 8) bus.cmd_valid = 1'b0;
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_color = 2'd0;
        test_reset();
        test_r_to_b();
        test_wrap();
        test_noop();
        test_illegal();
        test_busy();
        test_reset_midpress();
        test_back_to_back();
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d completions still outstanding, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/btn_press_driver.md
Name: btn_press_driver

Overview:
Command-driven initiator that synthesizes clean button presses on a single `btn` line. It steps the downstream debounced RGB colour-cycler (R→G→B→R, one step per rising edge) to a requested colour. It tracks a shadow copy of the cycler's colour and issues the minimum number of presses. It sits between a host/test controller and the cycler's button input, replacing the physical button.

Parameters:
- HOLD_TICKS, 1000, cycles `btn` is held high per press; must exceed the downstream debounce interval.
- GAP_TICKS, 1000, cycles `btn` is held low after each press; must exceed the downstream debounce interval.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_color  input  2  target colour: 0=R, 1=G, 2=B, 3=illegal
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid & cmd_ready at a posedge
- btn  output  1  synthesized button level to the cycler
- cur_color  output  2  shadow colour (0..2), tracks presses already completed
- done  output  1  one-cycle pulse: command finished
- err  output  1  one-cycle pulse: illegal command rejected

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values, at the posedge with rst=1: state=IDLE, btn=0, cur_color=0, done=0, err=0, cmd_ready=1 the following cycle, press/tick counters=0.
- Reset overrides everything, including mid-press or mid-gap. The pending command is discarded and no done is issued. The shadow resets to 0, matching the cycler, which shares rst.
- States:
  - IDLE: cmd_ready=1, btn=0.
  - PRESS: btn=1, cmd_ready=0.
  - GAP: btn=0, cmd_ready=0.
- Accept in IDLE (define the accept cycle as cycle 0):
  - cmd_color==3: err=1 in cycle 1; stay IDLE; cur_color unchanged.
  - Otherwise n = (cmd_color − cur_color) mod 3, so n∈{0,1,2}.
  - n==0: done=1 in cycle 1; stay IDLE; btn stays 0.
  - n>0: latch n into a 2-bit remaining counter; go to PRESS with the tick counter at 0.
- PRESS: btn=1 for exactly HOLD_TICKS cycles. On the last one:
  - cur_color advances 0→1→2→0 (wraps, never reaches 3);
  - remaining decrements;
  - go to GAP.
- GAP: btn=0 for exactly GAP_TICKS cycles. On the last one:
  - remaining>0: go to PRESS;
  - else: go to IDLE, with done=1 in the first IDLE cycle (cmd_ready=1 in that same cycle).
- Timing for n presses:
  - btn high in cycles k·(H+G)+1 … k·(H+G)+H, for k=0..n−1;
  - done asserted in cycle n·(H+G)+1.
- cmd_valid while not IDLE: ignored, no queuing. cmd_color is sampled only at acceptance; later changes have no effect.
- Back-to-back: a command may be accepted in the same cycle done is high.
- done and err are never high together; each is high for exactly one cycle.
- Tick counter width: $clog2(max(HOLD_TICKS,GAP_TICKS)+1). The counter saturates/clears on every state change; no wrap inside a phase.
- btn is a registered output (glitch-free); no combinational path from cmd_* to btn.

Test Plan (H=4, G=3):
- Reset: rst high 2 cycles → btn=0, cur_color=0, cmd_ready=1, done=0, err=0; cmd_valid during rst is not accepted.
- R→B: cmd_color=2 at cycle 0, cur_color=0 → btn high cycles 1–4 and 8–11, low 5–7 and 12–14; cur_color=1 from cycle 5, 2 from cycle 12; done only in cycle 15; cmd_ready=0 in cycles 1–14.
- Wrap: from cur_color=2, cmd_color=0 → single press (btn high cycles 1–4); cur_color=0 from cycle 5; done in cycle 8. With the cycler attached, its LED output returns to red.
- No-op/illegal:
  - cmd_color equal to cur_color → done in cycle 1, btn never rises.
  - cmd_color=3 → err in cycle 1 only; btn=0; cur_color unchanged; cmd_ready stays 1.
- Busy/reset: new cmd_valid held during PRESS → ignored (cur_color ends at first target). rst at cycle 2 of a press → btn=0 and cur_color=0 from cycle 3; no done; IDLE with cmd_ready=1.
- Back-to-back: cmd_color=1 accepted; second cmd_color=2 presented continuously → accepted in the done cycle (cycle 8); its press starts cycle 9; final cur_color=2.
